// File: rtl/mixer_pkg.sv
// -----------------------------------------------------------------------------
// mixer_pkg
// Shared definitions for the speaker mixer and its output-stage helpers.
//   state_t    : mixer control states (IDLE -> ACCUM -> OUT -> IDLE)
//   GAIN_FRAC  : fractional bits of the unsigned Q1.7 gain
//   GAIN_UNITY : gain code for 1.0x
//   SAT_MAX/MIN: 16-bit signed clamp limits of the speaker feed
// -----------------------------------------------------------------------------
package mixer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam int GAIN_FRAC  = 7;
  localparam int GAIN_UNITY = 128;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/mix_saturate.sv
// -----------------------------------------------------------------------------
// mix_saturate
// Combinational scale-down of a gain-weighted accumulator and clamp to the
// signed DW-bit output range. Shared with the multi-speaker output bank.
// Ports:
//   acc     in  AW  signed accumulator (samples * Q1.7 gains, summed)
//   res     out DW  acc >>> GAIN_FRAC, clamped to [SAT_MIN, SAT_MAX]
//   clipped out 1   high when the clamp changed the value
// -----------------------------------------------------------------------------
module mix_saturate
  import mixer_pkg::*;
#(
  parameter int AW = 27,
  parameter int DW = 16
) (
  input  logic signed [AW-1:0] acc,
  output logic signed [DW-1:0] res,
  output logic                 clipped
);

  localparam logic signed [AW-1:0] HI = AW'(SAT_MAX);
  localparam logic signed [AW-1:0] LO = AW'(SAT_MIN);

  // Arithmetic shift: negative values round toward -inf.
  logic signed [AW-1:0] shifted;

  function automatic logic signed [DW-1:0] clamp(input logic signed [AW-1:0] v);
    if (v > HI)
      return DW'(SAT_MAX);
    else if (v < LO)
      return DW'(SAT_MIN);
    else
      return v[DW-1:0];
  endfunction

  function automatic logic is_clipped(input logic signed [AW-1:0] v);
    return (v > HI) || (v < LO);
  endfunction

  assign shifted = acc >>> GAIN_FRAC;
  assign res     = clamp(shifted);
  assign clipped = is_clipped(shifted);

endmodule

// File: rtl/speaker_mixer.sv
// -----------------------------------------------------------------------------
// speaker_mixer
// Time-multiplexed gain-and-sum of NCH delayed source channels into one
// speaker feed. One MAC per clock after each sample_tick; the result is scaled
// by the Q1.7 gain format, saturated to 16 bits and presented with a one-cycle
// mix_valid pulse NCH+2 cycles after the tick.
// Ports:
//   clk          in   1       system clock
//   rst_n        in   1       synchronous reset, active-low
//   sample_tick  in   1       44 kHz strobe: start a new mix
//   samples_in   in   NCH*DW  channel i at [i*DW +: DW], signed
//   gains        in   NCH*GW  channel i gain at [i*GW +: GW], unsigned Q1.7
//   mix_out      out  DW      saturated mix, held until the next result
//   mix_valid    out  1       one-cycle pulse when mix_out updates
//   busy         out  1       mix in progress
//   overrun      out  1       one-cycle pulse: tick arrived while busy
//   sat_count    out  16      clip event counter
// Build option: define MIXER_SAT_COUNT_EN to build the saturating clip
// counter; otherwise sat_count is constant zero.
// -----------------------------------------------------------------------------
module speaker_mixer
  import mixer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int DW  = 16,
  parameter int GW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_tick,
  input  logic [NCH*DW-1:0]     samples_in,
  input  logic [NCH*GW-1:0]     gains,
  output logic signed [DW-1:0]  mix_out,
  output logic                  mix_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           sat_count
);

  localparam int PW = DW + GW + 1;
  localparam int AW = PW + $clog2(NCH);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  state_t                state;
  logic [IW-1:0]         idx;

  logic signed [DW-1:0]  snap_smp  [NCH];
  logic [GW-1:0]         snap_gain [NCH];

  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  acc;
  logic signed [DW-1:0]  sat_res;

  // Gain is zero-extended so 255 stays +1.99x in the signed multiply.
  assign prod = snap_smp[idx] * $signed({1'b0, snap_gain[idx]});

  // Snapshot / accumulate datapath (no reset: qualified by the FSM)
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_tick) begin
      for (int i = 0; i < NCH; i++) begin
        snap_smp[i]  <= samples_in[i*DW +: DW];
        snap_gain[i] <= gains[i*GW +: GW];
      end
      acc <= '0;
    end else if (state == ACCUM) begin
      acc <= acc + AW'(prod);
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      mix_out   <= '0;
    end else begin
      mix_valid <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= ACCUM;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          overrun <= sample_tick;
          idx     <= idx + 1'b1;
          if (idx == LAST)
            state <= OUT;
        end
        OUT: begin
          overrun   <= sample_tick;
          mix_out   <= sat_res;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIXER_SAT_COUNT_EN
  logic        sat_clipped;
  logic [15:0] sat_cnt;

  mix_saturate #(.AW(AW), .DW(DW)) u_sat (
    .acc     (acc),
    .res     (sat_res),
    .clipped (sat_clipped)
  );

  // Sticky at all-ones; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (state == OUT && sat_clipped && sat_cnt != 16'hFFFF)
      sat_cnt <= sat_cnt + 16'd1;
  end

  assign sat_count = sat_cnt;
`else
  logic sat_clipped_unused;

  mix_saturate #(.AW(AW), .DW(DW)) u_sat (
    .acc     (acc),
    .res     (sat_res),
    .clipped (sat_clipped_unused)
  );

  assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_speaker_mixer.sv
// -----------------------------------------------------------------------------
// tb_speaker_mixer
// Self-checking bench for speaker_mixer (NCH=4, DW=16, GW=8): directed vector
// table, multi-cycle sequences (overrun, tick in OUT, snapshot, mid-mix reset)
// and randomized mixes compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_speaker_mixer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_tick;
  logic [63:0]        samples_in;
  logic [31:0]        gains;
  logic signed [15:0] mix_out;
  logic               mix_valid;
  logic               busy;
  logic               overrun;
  logic [15:0]        sat_count;

  int total = 0;
  int bad   = 0;
  int model_sat = 0;

  speaker_mixer #(.NCH(4), .DW(16), .GW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .samples_in  (samples_in),
    .gains       (gains),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic [31:0] g;
    longint      exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3);
    logic [63:0] r;
    r[15:0]  = c0[15:0];
    r[31:16] = c1[15:0];
    r[47:32] = c2[15:0];
    r[63:48] = c3[15:0];
    return r;
  endfunction

  function automatic logic [31:0] gk(input int g0, input int g1, input int g2, input int g3);
    logic [31:0] r;
    r[7:0]   = g0[7:0];
    r[15:8]  = g1[7:0];
    r[23:16] = g2[7:0];
    r[31:24] = g3[7:0];
    return r;
  endfunction

  // Reference: floor(sum(sample*gain) / 128), clamped to 16-bit signed.
  function automatic longint model(input logic [63:0] s, input logic [31:0] g, output bit clip);
    longint sum, q;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      longint sv, gv;
      sv = longint'($signed(s[i*16 +: 16]));
      gv = longint'(g[i*8 +: 8]);
      sum += sv * gv;
    end
    q = sum / 128;
    if (sum < 0 && (sum % 128) != 0) q = q - 1;
    clip = 1'b0;
    if (q > 32767) begin
      q = 32767;
      clip = 1'b1;
    end else if (q < -32768) begin
      q = -32768;
      clip = 1'b1;
    end
    return q;
  endfunction

  function automatic longint exp_sat();
`ifdef MIXER_SAT_COUNT_EN
    return longint'(model_sat);
`else
    return 0;
`endif
  endfunction

  task automatic do_mix(input logic [63:0] s, input logic [31:0] g, input longint exp, input string name);
    bit clip;
    longint mv;
    int lat;
    mv = model(s, g, clip);
    @(negedge clk);
    samples_in  = s;
    gains       = g;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk({name, "_busy"}, longint'(busy), 1);
    lat = 1;
    while (!mix_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, lat, 6);
    chk({name, "_out"}, longint'(mix_out), exp);
    chk({name, "_busy_end"}, longint'(busy), 0);
    if (clip && model_sat != 16'hFFFF) model_sat++;
    chk({name, "_satcnt"}, longint'(sat_count), exp_sat());
    @(negedge clk);
    chk({name, "_vld_pulse"}, longint'(mix_valid), 0);
  endtask

  // Cycle 0 carries tick_at[0]; each later cycle c drives tick_at[c], and
  // optionally swaps samples (chg_at) or asserts reset for one cycle (rst_at).
  task automatic run_seq(input logic [63:0] s, input logic [31:0] g, input logic [31:0] tick_at,
                         input int ncyc, input logic [63:0] s2, input int chg_at, input int rst_at,
                         output int vcnt, output int ocnt, output int first_v, output int last_c,
                         output longint last_v);
    vcnt = 0; ocnt = 0; first_v = -1; last_c = -1; last_v = 0;
    @(negedge clk);
    samples_in  = s;
    gains       = g;
    rst_n       = 1'b1;
    sample_tick = tick_at[0];
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (mix_valid) begin
        vcnt++;
        if (first_v < 0) first_v = c;
        last_c = c;
        last_v = longint'(mix_out);
      end
      if (overrun) ocnt++;
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("rst_mid_out", longint'(mix_out), 0);
        chk("rst_mid_busy", longint'(busy), 0);
        chk("rst_mid_ovr", longint'(overrun), 0);
        chk("rst_mid_sat", longint'(sat_count), 0);
      end
      sample_tick = tick_at[c];
      if (c == chg_at) samples_in = s2;
      rst_n = (c == rst_at) ? 1'b0 : 1'b1;
      if (c == rst_at) model_sat = 0;
    end
    sample_tick = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int vcnt, ocnt, fv, lc;
    longint lv;
    bit clip;
    logic [63:0] sa, sb;
    logic [31:0] ga;

    vt[0] = '{pk(1000, 0, 0, 0),                 gk(128, 0, 0, 0),       1000};
    vt[1] = '{pk(2000, 2000, 2000, 2000),        gk(64, 64, 64, 64),     4000};
    vt[2] = '{pk(-3, 0, 0, 0),                   gk(64, 0, 0, 0),        -2};
    vt[3] = '{pk(30000, 30000, 30000, 30000),    gk(255, 255, 255, 255), 32767};
    vt[4] = '{pk(-30000, -30000, -30000, -30000), gk(255, 255, 255, 255), -32768};
    vt[5] = '{pk(100, -200, 300, -400),          gk(128, 128, 128, 128), -200};
    vt[6] = '{pk(-1, 0, 0, 0),                   gk(1, 0, 0, 0),         -1};
    vt[7] = '{pk(32767, 0, 0, 0),                gk(128, 0, 0, 0),       32767};
    vt[8] = '{pk(-32768, 0, 0, 0),               gk(128, 0, 0, 0),       -32768};
    vt[9] = '{pk(12345, -777, 999, 5),           gk(0, 0, 0, 0),         0};

    rst_n = 1'b0;
    sample_tick = 1'b1;
    samples_in = '0;
    gains = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", longint'(mix_out), 0);
    chk("rst_vld", longint'(mix_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovr", longint'(overrun), 0);
    chk("rst_sat", longint'(sat_count), 0);
    sample_tick = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      do_mix(vt[i].s, vt[i].g, vt[i].exp, $sformatf("vec%0d", i));

    // Overrun three cycles in, plus samples changed mid-mix.
    sa = pk(1000, -2000, 3000, 400);
    sb = pk(-9000, 9000, 7, 7);
    ga = gk(128, 64, 32, 200);
    run_seq(sa, ga, 32'h0000_0009, 12, sb, 2, -1, vcnt, ocnt, fv, lc, lv);
    chk("ovr_vcnt", vcnt, 1);
    chk("ovr_ocnt", ocnt, 1);
    chk("ovr_lat", fv, 6);
    chk("ovr_snap", lv, model(sa, ga, clip));

    // Tick in the OUT cycle is dropped; tick right after mix_valid starts.
    run_seq(sb, ga, 32'h0000_00A1, 16, sb, -1, -1, vcnt, ocnt, fv, lc, lv);
    chk("outtick_vcnt", vcnt, 2);
    chk("outtick_ocnt", ocnt, 1);
    chk("outtick_first", fv, 6);
    chk("outtick_second", lc, 13);
    chk("outtick_val", lv, model(sb, ga, clip));

    // Reset in cycle 3 of a mix, with a tick held during reset.
    run_seq(sa, ga, 32'h0000_0009, 12, sa, -1, 3, vcnt, ocnt, fv, lc, lv);
    chk("rst_seq_vcnt", vcnt, 0);
    chk("rst_seq_ocnt", ocnt, 0);
    do_mix(sa, ga, model(sa, ga, clip), "post_rst");

    for (int n = 0; n < 40; n++) begin
      logic [63:0] rs;
      logic [31:0] rg;
      rs = {$urandom, $urandom};
      rg = $urandom;
      if (n % 4 == 1) rg = rg & 32'h3F3F3F3F;
      do_mix(rs, rg, model(rs, rg, clip), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
